// File: rtl/mips_div_pkg.sv
// Shared divider definitions: state encodings, counter width and the result
// slice indices that EX and HiLo both use.
package mips_div_pkg;

  localparam int unsigned DIV_DATA_W = 32;
  localparam int unsigned DIV_CNT_W  = $clog2(DIV_DATA_W) + 1;

  localparam logic [1:0] DIV_IDLE   = 2'd0;
  localparam logic [1:0] DIV_BYZERO = 2'd1;
  localparam logic [1:0] DIV_ON     = 2'd2;
  localparam logic [1:0] DIV_END    = 2'd3;

  // {hi, lo} = {remainder, quotient}
  localparam int unsigned HI_MSB = 2 * DIV_DATA_W - 1;
  localparam int unsigned HI_LSB = DIV_DATA_W;
  localparam int unsigned LO_MSB = DIV_DATA_W - 1;
  localparam int unsigned LO_LSB = 0;

  typedef enum logic [1:0] {
    StIdle   = DIV_IDLE,
    StByZero = DIV_BYZERO,
    StOn     = DIV_ON,
    StEnd    = DIV_END
  } div_state_e;

endpackage

// File: rtl/div_sign_fix.sv
// Applies the signed-division sign correction to a magnitude quotient and
// remainder; the output is {remainder, quotient}.
module div_sign_fix #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0]   quo_raw_i,
  input  logic [DATA_W-1:0]   rem_raw_i,
  input  logic                sign_a_i,
  input  logic                sign_b_i,
  input  logic                signed_div_i,
  output logic [2*DATA_W-1:0] fixed_o
);

  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem;

  always_comb begin
    quo = (signed_div_i && (sign_a_i ^ sign_b_i)) ? -quo_raw_i : quo_raw_i;
    // Remainder follows the dividend's sign.
    rem = (signed_div_i && sign_a_i) ? -rem_raw_i : rem_raw_i;
    fixed_o = {rem, quo};
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle restoring divider (DIV/DIVU), one quotient bit per cycle.
// Define DIV_EARLY_OUT_EN to finish at once when |dividend| < |divisor|.
module mul_div_unit
  import mips_div_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                signed_div,
  input  logic                annul,
  input  logic [DATA_W-1:0]   dividend,
  input  logic [DATA_W-1:0]   divisor,
  output logic [2*DATA_W-1:0] result,
  output logic                ready,
  output logic                busy
);

  localparam int unsigned CntW = $clog2(DATA_W) + 1;

  div_state_e          state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   div_q, div_d;
  logic                sign_a_q, sign_a_d;
  logic                sign_b_q, sign_b_d;
  logic                sdiv_q, sdiv_d;
  logic [2*DATA_W-1:0] result_q, result_d;

  logic [DATA_W:0]     shifted;
  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   iter_rem;
  logic [DATA_W-1:0]   iter_quo;
  logic                early_hit;
  logic [DATA_W-1:0]   fix_quo_in;
  logic [DATA_W-1:0]   fix_rem_in;
  logic [2*DATA_W-1:0] fixed;

  // One restoring step; the quotient register doubles as the dividend shifter.
  always_comb begin
    shifted  = {rem_q, quo_q[DATA_W-1]};
    diff     = shifted - {1'b0, div_q};
    iter_rem = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
    iter_quo = {quo_q[DATA_W-2:0], ~diff[DATA_W]};
  end

`ifdef DIV_EARLY_OUT_EN
  assign early_hit = (state_q == StOn) && (cnt_q == '0) && (quo_q < div_q);
`else
  assign early_hit = 1'b0;
`endif

  assign fix_quo_in = early_hit ? '0    : iter_quo;
  assign fix_rem_in = early_hit ? quo_q : iter_rem;

  div_sign_fix #(
    .DATA_W(DATA_W)
  ) u_sign_fix (
    .quo_raw_i   (fix_quo_in),
    .rem_raw_i   (fix_rem_in),
    .sign_a_i    (sign_a_q),
    .sign_b_i    (sign_b_q),
    .signed_div_i(sdiv_q),
    .fixed_o     (fixed)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    sdiv_d   = sdiv_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (divisor == '0) begin
            state_d = StByZero;
            quo_d   = dividend;  // raw dividend becomes the remainder
          end else begin
            state_d  = StOn;
            sdiv_d   = signed_div;
            sign_a_d = signed_div & dividend[DATA_W-1];
            sign_b_d = signed_div & divisor[DATA_W-1];
            quo_d    = sign_a_d ? -dividend : dividend;
            div_d    = sign_b_d ? -divisor : divisor;
            rem_d    = '0;
            cnt_d    = '0;
          end
        end
      end
      StByZero: begin
        state_d  = StEnd;
        result_d = {quo_q, {DATA_W{1'b1}}};
      end
      StOn: begin
        rem_d = iter_rem;
        quo_d = iter_quo;
        cnt_d = cnt_q + CntW'(1);
        if (early_hit || (cnt_q == CntW'(DATA_W - 1))) begin
          state_d  = StEnd;
          result_d = fixed;
        end
      end
      StEnd: begin
        if (!start) begin
          state_d  = StIdle;
          result_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (annul) begin
      state_d  = StIdle;
      result_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      sdiv_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      sdiv_q   <= sdiv_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;
  assign ready  = (state_q == StEnd);
  assign busy   = (state_q == StOn) || (state_q == StByZero);

endmodule
